// File: rtl/pwm_softstart_sequencer.sv
// Sequencer for the buck PWM generator: soft-start ramp, duty clamp, slew-limited run and fault latch.
// Define PWM_SOFTSTOP_EN to ramp the duty down (STOP state) on enable loss instead of cutting it at once.
module pwm_softstart_sequencer #(
  parameter int counter_width = 12,
  parameter int PERIOD_MIN    = 16,
  parameter int DUTY_MARGIN   = 2
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic                     enable_i,
  input  logic                     fault_i,
  input  logic                     fault_clear_i,
  input  logic [counter_width-1:0] period_req_i,
  input  logic [counter_width-1:0] target_duty_i,
  input  logic [counter_width-1:0] step_i,
  input  logic [counter_width-1:0] pwm_counter_i,
  output logic [counter_width-1:0] period_out_o,
  output logic [counter_width-1:0] comparator_out_o,
  output logic                     pwm_en_o,
  output logic                     ramp_done_o,
  output logic                     fault_latched_o,
  output logic [2:0]               state_o
);
  localparam int W = counter_width;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RAMP  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FAULT = 3'd3,
    ST_STOP  = 3'd4
  } state_t;

  localparam logic [W-1:0] PMIN   = W'(PERIOD_MIN);
  localparam logic [W-1:0] PMAX   = {{(W-1){1'b1}}, 1'b0};
  localparam logic [W-1:0] MARGIN = W'(DUTY_MARGIN);

  state_t         state_q;
  logic [W-1:0]   period_q;
  logic [W-1:0]   comp_q;
  logic           pwm_en_q;
  logic           ramp_done_q;
  logic           fault_q;

  logic [W-1:0]   period_d;
  logic [W-1:0]   step_eff;
  logic [W-1:0]   duty_lim;
  logic [W-1:0]   period_room;
  logic           bnd;
  logic [W:0]     comp_sum;
  logic [W-1:0]   comp_up_d;
  logic [W-1:0]   comp_slew_d;

  always_comb begin
    period_d = period_req_i;
    if (period_req_i < PMIN) period_d = PMIN;
    else if (period_req_i > PMAX) period_d = PMAX;
  end

  assign step_eff    = (step_i == '0) ? {{(W-1){1'b0}}, 1'b1} : step_i;
  assign period_room = (period_q < MARGIN) ? '0 : period_q - MARGIN;
  assign duty_lim    = (target_duty_i < period_room) ? target_duty_i : period_room;

  // Generator counter runs one past period_out; compare one bit wider so period_out+1 cannot wrap.
  assign bnd = ({1'b0, pwm_counter_i} == ({1'b0, period_q} + {{W{1'b0}}, 1'b1}));

  assign comp_sum  = {1'b0, comp_q} + {1'b0, step_eff};
  assign comp_up_d = (comp_sum >= {1'b0, duty_lim}) ? duty_lim : comp_sum[W-1:0];

  // RUN slews toward duty_lim from either side, never overshooting it.
  always_comb begin
    comp_slew_d = comp_up_d;
    if (comp_q > duty_lim) begin
      comp_slew_d = ((comp_q - duty_lim) > step_eff) ? comp_q - step_eff : duty_lim;
    end
  end

`ifdef PWM_SOFTSTOP_EN
  logic [W-1:0] comp_dn_d;
  assign comp_dn_d = (comp_q > step_eff) ? comp_q - step_eff : '0;
`endif

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      period_q    <= PMIN;
      comp_q      <= '0;
      pwm_en_q    <= 1'b0;
      ramp_done_q <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      if (bnd && state_q != ST_FAULT) period_q <= period_d;

      if (fault_i && state_q != ST_FAULT) begin
        state_q     <= ST_FAULT;
        comp_q      <= '0;
        pwm_en_q    <= 1'b0;
        ramp_done_q <= 1'b0;
        fault_q     <= 1'b1;
      end else begin
        case (state_q)
          // comp_q is always 0 in IDLE, so comp_up_d is min(step, duty_lim) here.
          ST_IDLE: begin
            if (bnd && enable_i) begin
              state_q  <= ST_RAMP;
              comp_q   <= comp_up_d;
              pwm_en_q <= 1'b1;
            end
          end
          ST_RAMP, ST_RUN: begin
            if (!enable_i) begin
`ifdef PWM_SOFTSTOP_EN
              state_q     <= ST_STOP;
              ramp_done_q <= 1'b0;
`else
              state_q     <= ST_IDLE;
              comp_q      <= '0;
              pwm_en_q    <= 1'b0;
              ramp_done_q <= 1'b0;
`endif
            end else if (bnd) begin
              if (state_q == ST_RAMP) begin
                comp_q <= comp_up_d;
                if (comp_up_d == duty_lim) begin
                  state_q     <= ST_RUN;
                  ramp_done_q <= 1'b1;
                end
              end else begin
                comp_q <= comp_slew_d;
              end
            end
          end
`ifdef PWM_SOFTSTOP_EN
          ST_STOP: begin
            if (bnd) begin
              if (enable_i) begin
                state_q <= ST_RAMP;
                comp_q  <= comp_up_d;
              end else begin
                comp_q <= comp_dn_d;
                if (comp_dn_d == '0) begin
                  state_q  <= ST_IDLE;
                  pwm_en_q <= 1'b0;
                end
              end
            end
          end
`endif
          ST_FAULT: begin
            if (fault_clear_i && !fault_i && !enable_i) begin
              state_q <= ST_IDLE;
              fault_q <= 1'b0;
            end
          end
          default: begin
            state_q  <= ST_IDLE;
            comp_q   <= '0;
            pwm_en_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period_out_o     = period_q;
  assign comparator_out_o = comp_q;
  assign pwm_en_o         = pwm_en_q;
  assign ramp_done_o      = ramp_done_q;
  assign fault_latched_o  = fault_q;
  assign state_o          = state_q;

endmodule
